// File: rtl/mesh_sched_pkg.sv
// Shared definitions for the mesh job scheduler: FSM state codes, the
// default compute latency and the default weight count.
package mesh_sched_pkg;

   // FSM state codes
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Default mesh geometry and the number of weights it holds
   localparam int unsigned DEF_ROWS = 16;
   localparam int unsigned DEF_COLS = 16;
   localparam int unsigned WCOUNT   = DEF_ROWS * DEF_COLS;

   // Start pulse to valid result: skew through rows and columns plus edges
   function automatic int unsigned compute_lat_default(input int unsigned rows,
                                                       input int unsigned cols);
      return rows + cols + 2;
   endfunction

endpackage

// File: rtl/mesh_job_scheduler_preload_seq.sv
// LOAD-phase weight sequencer: walks the preload address across the mesh,
// registers each accepted weight beat onto the preload port and flags the
// final beat to the scheduler FSM.
module mesh_preload_seq
   import mesh_sched_pkg::*;
#(
   parameter int unsigned DW     = 8,
   parameter int unsigned AW     = 8,
   parameter int unsigned NBEATS = WCOUNT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          beat,
   input  logic [DW-1:0] w_data,
   output logic          preload_valid,
   output logic [AW-1:0] preload_addr,
   output logic [DW-1:0] preload_data,
   output logic          load_done_c
);

   logic [AW-1:0] addr;

   // Last weight of the matrix is being accepted this cycle
   always_comb begin
      load_done_c = beat && (addr == AW'(NBEATS - 1));
   end

   // Address counter; it stops on the last beat and never wraps into a second pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (clear) begin
         addr <= '0;
      end else if (beat && !load_done_c) begin
         addr <= addr + AW'(1);
      end
   end

   // Registered preload write, one cycle behind its beat; valid drops in gaps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preload_valid <= 1'b0;
         preload_addr  <= '0;
         preload_data  <= '0;
      end else begin
         preload_valid <= beat;
         if (beat) begin
            preload_addr <= addr;
            preload_data <= w_data;
         end
      end
   end

endmodule

// File: rtl/mesh_job_scheduler.sv
// Mesh job scheduler: accepts one matrix-vector job, streams weights into the
// mesh (unless they are still resident), pulses start, waits the fixed
// compute latency and returns the captured result over valid/ready.
// Optional: define MESH_SCHED_PERF_EN to add the perf_cycles output.
module mesh_job_scheduler
   import mesh_sched_pkg::*;
#(
   parameter int unsigned DW          = 8,
   parameter int unsigned ROWS        = DEF_ROWS,
   parameter int unsigned COLS        = DEF_COLS,
   parameter int unsigned ROW_W       = 4,
   parameter int unsigned COL_W       = 4,
   parameter int unsigned ACC_W       = 16,
   parameter int unsigned LAT_W       = 6,
   parameter int unsigned COMPUTE_LAT = compute_lat_default(ROWS, COLS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic                    job_skip_load,
   input  logic [COLS*DW-1:0]      job_x,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [DW-1:0]           w_data,
   output logic                    preload_valid,
   output logic [ROW_W+COL_W-1:0]  preload_addr,
   output logic [DW-1:0]           preload_data,
   output logic                    start,
   output logic [COLS*DW-1:0]      x_vector_flat,
   input  logic [ROWS*ACC_W-1:0]   result_flat,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ROWS*ACC_W-1:0]   res_data,
   output logic                    busy
`ifdef MESH_SCHED_PERF_EN
   ,
   output logic [15:0]             perf_cycles
`endif
);

   localparam int unsigned AW = ROW_W + COL_W;

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic             wload;
   logic [LAT_W-1:0] wait_cnt;
   logic             accept_c;
   logic             beat_c;
   logic             load_clear_c;
   logic             load_done_c;
   logic             res_hs_c;
   logic             wait_done_c;

   // Handshake qualifiers used by both the FSM and the datapath
   always_comb begin
      accept_c     = (state == S_IDLE) && job_valid && job_ready;
      beat_c       = (state == S_LOAD) && w_valid && w_ready;
      res_hs_c     = (state == S_DONE) && res_valid && res_ready;
      wait_done_c  = (state == S_WAIT) && (wait_cnt == '0);
      load_clear_c = accept_c && !(job_skip_load && wload);
   end

   // Next-state logic; a skip request without resident weights still loads
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept_c) begin
               state_next = (job_skip_load && wload) ? S_START : S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_done_c) begin
               state_next = S_START;
            end
         end
         S_START: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (wait_done_c) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (res_hs_c) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register and state-decoded handshake/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         job_ready <= 1'b0;
         w_ready   <= 1'b0;
         start     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         job_ready <= (state_next == S_IDLE);
         w_ready   <= (state_next == S_LOAD);
         start     <= (state_next == S_START);
         busy      <= (state_next != S_IDLE);
      end
   end

   // Weights-resident flag: dropped when a reload begins, set on its last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wload <= 1'b0;
      end else if (load_clear_c) begin
         wload <= 1'b0;
      end else if (load_done_c) begin
         wload <= 1'b1;
      end
   end

   // Activation latch, held from acceptance until the next job
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_vector_flat <= '0;
      end else if (accept_c) begin
         x_vector_flat <= job_x;
      end
   end

   // Compute-wait counter, loaded in START and counted down in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == S_START) begin
         wait_cnt <= LAT_W'(COMPUTE_LAT - 1);
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
         wait_cnt <= wait_cnt - LAT_W'(1);
      end
   end

   // Result capture and valid/ready return channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
      end else if (wait_done_c) begin
         res_valid <= 1'b1;
         res_data  <= result_flat;
      end else if (res_hs_c) begin
         res_valid <= 1'b0;
      end
   end

`ifdef MESH_SCHED_PERF_EN
   // Job latency counter; the acceptance cycle counts as the first cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
      end else if (accept_c) begin
         perf_cycles <= 16'd1;
      end else if (((state == S_LOAD) || (state == S_START) || (state == S_WAIT)) &&
                   (perf_cycles != 16'hFFFF)) begin
         perf_cycles <= perf_cycles + 16'd1;
      end
   end
`endif

   mesh_preload_seq #(
      .DW     (DW),
      .AW     (AW),
      .NBEATS (ROWS * COLS)
   ) u_preload_seq (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (load_clear_c),
      .beat          (beat_c),
      .w_data        (w_data),
      .preload_valid (preload_valid),
      .preload_addr  (preload_addr),
      .preload_data  (preload_data),
      .load_done_c   (load_done_c)
   );

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Directed bench for mesh_job_scheduler with a behavioural mesh that only
// presents its result on the exact cycle the compute latency expires.
// Define MESH_SCHED_PERF_EN to also check perf_cycles.
`timescale 1ns/1ps
module tb_mesh_job_scheduler;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          job_valid;
   logic          job_ready;
   logic          job_skip_load;
   logic [127:0]  job_x;
   logic          w_valid;
   logic          w_ready;
   logic [7:0]    w_data;
   logic          preload_valid;
   logic [7:0]    preload_addr;
   logic [7:0]    preload_data;
   logic          start;
   logic [127:0]  x_vector_flat;
   logic [255:0]  result_flat;
   logic          res_valid;
   logic          res_ready;
   logic [255:0]  res_data;
   logic          busy;
`ifdef MESH_SCHED_PERF_EN
   logic [15:0]   perf_cycles;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   localparam logic [127:0] X1 = 128'h0102_0304_0506_0708_F9FA_FBFC_FDFE_FF00;
   localparam logic [127:0] X2 = 128'h7F80_1122_3344_5566_778A_9BAC_BDCE_DFE0;

   always #5 clk = ~clk;

   mesh_job_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_skip_load (job_skip_load),
      .job_x         (job_x),
      .w_valid       (w_valid),
      .w_ready       (w_ready),
      .w_data        (w_data),
      .preload_valid (preload_valid),
      .preload_addr  (preload_addr),
      .preload_data  (preload_data),
      .start         (start),
      .x_vector_flat (x_vector_flat),
      .result_flat   (result_flat),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .busy          (busy)
`ifdef MESH_SCHED_PERF_EN
      ,
      .perf_cycles   (perf_cycles)
`endif
   );

   // Weight stimulus patterns
   function automatic logic [7:0] wpat(input int pat, input int i);
      if (pat == 0) return 8'(i);
      return 8'(i * 7 + 3);
   endfunction

   // Expected mesh output from the stimulus weights and activation vector
   function automatic logic [255:0] exp_res(input int pat, input logic [127:0] x);
      logic [255:0] r;
      int acc;
      r = '0;
      for (int rr = 0; rr < 16; rr++) begin
         acc = 0;
         for (int cc = 0; cc < 16; cc++)
            acc += int'($signed(wpat(pat, rr * 16 + cc))) * int'($signed(x[cc*8 +: 8]));
         r[rr*16 +: 16] = 16'(acc);
      end
      return r;
   endfunction

   // Behavioural mesh: weights come only from the DUT preload port
   logic [7:0]   wmem [256];
   int           lat_cnt = 0;
   logic [255:0] y_hold = '0;

   function automatic logic [255:0] mesh_model(input logic [127:0] x);
      logic [255:0] r;
      int acc;
      r = '0;
      for (int rr = 0; rr < 16; rr++) begin
         acc = 0;
         for (int cc = 0; cc < 16; cc++)
            acc += int'($signed(wmem[rr*16 + cc])) * int'($signed(x[cc*8 +: 8]));
         r[rr*16 +: 16] = 16'(acc);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (preload_valid) wmem[preload_addr] = preload_data;
      if (start) begin
         y_hold  <= mesh_model(x_vector_flat);
         lat_cnt <= 1;
      end else if (lat_cnt != 0 && lat_cnt < 100) begin
         lat_cnt <= lat_cnt + 1;
      end
   end

   assign result_flat = (lat_cnt == 34) ? y_hold : {16{16'hBAD0}};

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete job from request to result handshake
   task automatic run_job(input logic skip, input logic [127:0] x, input int pat,
                          input logic gaps, input logic expect_load, input int hold);
      int guard;
      int i;
      int k;
      logic gap;
      logic stray;
      logic [255:0] exp;
      exp = exp_res(pat, x);
      guard = 0;
      while (!job_ready && guard < 20) begin
         tick();
         guard++;
      end
      check("job_ready_idle", 256'(job_ready), 256'(1));
      job_valid     = 1'b1;
      job_skip_load = skip;
      job_x         = x;
      tick();
      job_valid     = 1'b0;
      job_x         = ~x;
      if (expect_load) begin
         check("w_ready_load", 256'(w_ready), 256'(1));
         i = 0;
         k = 0;
         while (i < 256 && k < 1000) begin
            gap     = gaps && (k % 3 == 2);
            w_valid = !gap;
            w_data  = wpat(pat, i);
            tick();
            if (gap) begin
               check("preload_gap", 256'(preload_valid), 256'(0));
            end else begin
               check("preload_beat", 256'({preload_valid, preload_addr, preload_data}),
                     256'({1'b1, 8'(i), wpat(pat, i)}));
               check("start_timing", 256'(start), 256'(i == 255));
               i++;
            end
            k++;
         end
         w_valid = 1'b0;
      end else begin
         check("start_after_accept", 256'(start), 256'(1));
         w_valid = 1'b1;
         w_data  = 8'h55;
      end
      check("x_latched", 256'(x_vector_flat), 256'(x));
      stray = 1'b0;
      guard = 0;
      while (!res_valid && guard < 100) begin
         tick();
         guard++;
         if (w_ready || preload_valid) stray = 1'b1;
      end
      w_valid = 1'b0;
      check("res_latency", 256'(guard), 256'(35));
      check("no_stray_load", 256'(stray), 256'(0));
      check("res_data", res_data, exp);
      check("x_stable", 256'(x_vector_flat), 256'(x));
`ifdef MESH_SCHED_PERF_EN
      if (!expect_load) check("perf_cycles", 256'(perf_cycles), 256'(36));
`endif
      for (int h = 0; h < hold; h++) begin
         job_valid = 1'b1;
         tick();
         check("hold_state", 256'({res_valid, job_ready, busy}), 256'(3'b101));
         check("hold_data", res_data, exp);
      end
      job_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("after_handshake", 256'({res_valid, job_ready, busy}), 256'(3'b010));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      job_valid = 1'b0;
      job_skip_load = 1'b0;
      job_x = '0;
      w_valid = 1'b0;
      w_data = '0;
      res_ready = 1'b0;
      tick();
      tick();
      check("rst_ctrl", 256'({job_ready, w_ready, busy, start, res_valid, preload_valid}), 256'(0));
      check("rst_data", 256'({x_vector_flat, preload_addr, preload_data}), 256'(0));
      check("rst_res", res_data, 256'(0));
      rst_n = 1'b1;
      tick();
      check("job_ready_post_rst", 256'(job_ready), 256'(1));

      // Full load, then a resident-weight job with a stalled consumer
      run_job(1'b0, X1, 0, 1'b0, 1'b1, 0);
      run_job(1'b1, X2, 0, 1'b0, 1'b0, 10);
      // Gapped weight stream with a new pattern
      run_job(1'b0, X1, 1, 1'b1, 1'b1, 0);
      run_job(1'b1, X1, 1, 1'b0, 1'b0, 0);

      // Reset in the middle of a load
      job_valid = 1'b1;
      job_skip_load = 1'b0;
      job_x = X2;
      tick();
      job_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         w_valid = 1'b1;
         w_data  = wpat(0, i);
         tick();
      end
      w_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", 256'({job_ready, w_ready, busy, start, res_valid, preload_valid}), 256'(0));
      check("midrst_data", 256'({x_vector_flat, preload_addr, preload_data}), 256'(0));
      #2;
      rst_n = 1'b1;
      tick();
      // Skip requested after reset must still reload
      run_job(1'b1, X2, 0, 1'b0, 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
